// File: rtl/stage_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : stage_if_fetch
// Description : ARM pipeline instruction-fetch stage. Owns the PC, fetches
//               words from a variable-latency instruction memory over a
//               req/ready handshake, and hands {inst, pcOut, valid} to the
//               IF/ID register. Supports hazard freeze and EX-stage branch
//               redirects, including redirects that land mid-fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        freeze,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] inst,
  output logic [31:0] pcOut,
  output logic        valid
);

  // FETCH: request at pc. HOLD: a word was captured under freeze and waits
  // for the stall to clear. DRAIN: a redirect arrived while a request was
  // outstanding; the old request must complete before the new target issues.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;
  logic [31:0] drain_addr;
  logic [31:0] pc_next_seq;

  // Sequential successor; 32-bit arithmetic wraps silently.
  assign pc_next_seq = pc + PC_STEP;

  // Request is derived from state and forced low while reset is held, so the
  // memory never sees a request during reset. In DRAIN the abandoned address
  // is kept on the bus until the memory completes it.
  always_comb begin
    imemReq  = rst && (state != HOLD);
    imemAddr = (state == DRAIN) ? drain_addr : pc;
  end

  // Fetch state machine, PC, capture buffers and registered IF/ID outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      pcOut      <= 32'd0;
      valid      <= 1'b0;
      hold_inst  <= 32'd0;
      hold_pc    <= 32'd0;
      drain_addr <= 32'd0;
    end else if (branchTaken) begin
      // Redirect outranks freeze and capture: squash whatever is in flight
      // or held, and emit a bubble.
      pc    <= branchAddr;
      valid <= 1'b0;
      case (state)
        FETCH: begin
          if (!imemReady) begin
            drain_addr <= pc;
            state      <= DRAIN;
          end
        end
        HOLD:    state <= FETCH;
        DRAIN:   if (imemReady) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imemReady) begin
            pc <= pc_next_seq;
            if (freeze) begin
              // Park the word; IF/ID must not change while stalled.
              hold_inst <= imemData;
              hold_pc   <= pc_next_seq;
              state     <= HOLD;
            end else begin
              inst  <= imemData;
              pcOut <= pc_next_seq;
              valid <= 1'b1;
            end
          end else if (!freeze) begin
            valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!freeze) begin
            inst  <= hold_inst;
            pcOut <= hold_pc;
            valid <= 1'b1;
            state <= FETCH;
          end
        end
        DRAIN: begin
          // Completion of the stale request is discarded; pc already holds
          // the redirect target.
          if (imemReady) state <= FETCH;
          if (!freeze)   valid <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_if_fetch
// Description : Directed self-checking bench for stage_if_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_if_fetch;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] inst;
  logic [31:0] pcOut;
  logic        valid;

  int tests;
  int fails;

  stage_if_fetch #(
    .RESET_PC(32'd0),
    .PC_STEP (32'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .branchTaken(branchTaken),
    .branchAddr (branchAddr),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemReady  (imemReady),
    .imemData   (imemData),
    .inst       (inst),
    .pcOut      (pcOut),
    .valid      (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; land 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two cycles, then release with all inputs idle.
  task automatic do_reset();
    rst = 1'b0; freeze = 1'b0; branchTaken = 1'b0; branchAddr = 32'd0;
    imemReady = 1'b0; imemData = 32'd0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; branchTaken = 1'b0; branchAddr = 32'd0;
    imemReady = 1'b1; imemData = 32'hFFFF_FFFF;
    step();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (inst !== 32'd0) begin fails++; $display("FAIL reset_inst: got %h want 0", inst); end
    tests++; if (pcOut !== 32'd0) begin fails++; $display("FAIL reset_pcout: got %h want 0", pcOut); end
    tests++; if (imemReq !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imemReq); end
    imemReady = 1'b0;
    rst = 1'b1;
    #1;
    tests++; if (imemReq !== 1'b1) begin fails++; $display("FAIL reset_req_release: got %b want 1", imemReq); end
    tests++; if (imemAddr !== 32'd0) begin fails++; $display("FAIL reset_addr: got %h want 0", imemAddr); end
  endtask

  // Zero-wait memory returning data equal to the address.
  task automatic test_zero_wait();
    do_reset();
    imemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (imemAddr !== 32'(4 * i)) begin fails++; $display("FAIL zw_addr[%0d]: got %h want %h", i, imemAddr, 32'(4 * i)); end
      imemData = 32'(4 * i);
      step();
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL zw_valid[%0d]: got %b want 1", i, valid); end
      tests++; if (inst !== 32'(4 * i)) begin fails++; $display("FAIL zw_inst[%0d]: got %h want %h", i, inst, 32'(4 * i)); end
      tests++; if (pcOut !== 32'(4 * i + 4)) begin fails++; $display("FAIL zw_pcout[%0d]: got %h want %h", i, pcOut, 32'(4 * i + 4)); end
    end
    imemReady = 1'b0;
  endtask

  // Three-cycle memory: address stable, valid only in delivery cycle.
  task automatic test_latency();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 3; c++) begin
        imemReady = (c == 2);
        imemData  = 32'hA000_0000 | 32'(4 * f);
        #1;
        tests++; if (imemAddr !== 32'(4 * f) || imemReq !== 1'b1) begin fails++; $display("FAIL lat_addr[%0d.%0d]: got %h/%b want %h/1", f, c, imemAddr, imemReq, 32'(4 * f)); end
        step();
        if (c < 2) begin
          tests++; if (valid !== 1'b0) begin fails++; $display("FAIL lat_bubble[%0d.%0d]: got %b want 0", f, c, valid); end
        end
      end
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL lat_valid[%0d]: got %b want 1", f, valid); end
      tests++; if (inst !== (32'hA000_0000 | 32'(4 * f))) begin fails++; $display("FAIL lat_inst[%0d]: got %h want %h", f, inst, 32'hA000_0000 | 32'(4 * f)); end
      tests++; if (pcOut !== 32'(4 * f + 4)) begin fails++; $display("FAIL lat_pcout[%0d]: got %h want %h", f, pcOut, 32'(4 * f + 4)); end
    end
    imemReady = 1'b0;
  endtask

  // Freeze in the capture cycle for 4 cycles, then release.
  task automatic test_freeze();
    do_reset();
    imemReady = 1'b1; imemData = 32'hD000_0000;
    step();
    imemData = 32'hD000_0004; freeze = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      imemData = 32'hBAD0_0000 | 32'(c);   // memory still says ready; must be ignored
      tests++; if (inst !== 32'hD000_0000 || pcOut !== 32'd4 || valid !== 1'b1) begin fails++; $display("FAIL frz_hold[%0d]: got %h/%h/%b want d0000000/4/1", c, inst, pcOut, valid); end
      tests++; if (imemReq !== 1'b0) begin fails++; $display("FAIL frz_req[%0d]: got %b want 0", c, imemReq); end
    end
    freeze = 1'b0; imemReady = 1'b0;
    step();
    tests++; if (inst !== 32'hD000_0004 || pcOut !== 32'd8 || valid !== 1'b1) begin fails++; $display("FAIL frz_release: got %h/%h/%b want d0000004/8/1", inst, pcOut, valid); end
    tests++; if (imemReq !== 1'b1 || imemAddr !== 32'd8) begin fails++; $display("FAIL frz_next_addr: got %b/%h want 1/8", imemReq, imemAddr); end
    step();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL frz_no_dup: got %b want 0", valid); end
  endtask

  // Redirect to 0x100 while a 3-cycle fetch of 0x8 is outstanding.
  task automatic test_branch_drain();
    do_reset();
    imemReady = 1'b1; imemData = 32'h1111_0000; step();
    imemData = 32'h1111_0004; step();
    imemReady = 1'b0;
    tests++; if (imemAddr !== 32'h8) begin fails++; $display("FAIL br_addr0: got %h want 8", imemAddr); end
    step();
    branchTaken = 1'b1; branchAddr = 32'h100;
    step();
    branchTaken = 1'b0;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL br_valid_squash: got %b want 0", valid); end
    tests++; if (imemAddr !== 32'h8 || imemReq !== 1'b1) begin fails++; $display("FAIL br_drain_addr: got %h/%b want 8/1", imemAddr, imemReq); end
    imemReady = 1'b1; imemData = 32'hDEAD_0008;
    step();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL br_drop: got %b want 0", valid); end
    tests++; if (imemAddr !== 32'h100) begin fails++; $display("FAIL br_target_addr: got %h want 100", imemAddr); end
    imemData = 32'hC000_0100;
    step();
    tests++; if (inst !== 32'hC000_0100 || pcOut !== 32'h104 || valid !== 1'b1) begin fails++; $display("FAIL br_deliver: got %h/%h/%b want c0000100/104/1", inst, pcOut, valid); end
    imemReady = 1'b0;
  endtask

  // Second redirect during DRAIN, then a redirect during HOLD.
  task automatic test_back_to_back();
    do_reset();
    branchTaken = 1'b1; branchAddr = 32'h100;
    step();
    branchAddr = 32'h200;
    tests++; if (imemAddr !== 32'h0) begin fails++; $display("FAIL b2b_drain_addr: got %h want 0", imemAddr); end
    step();
    branchTaken = 1'b0; imemReady = 1'b1; imemData = 32'hBAD0_0000;
    step();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL b2b_drop: got %b want 0", valid); end
    tests++; if (imemAddr !== 32'h200) begin fails++; $display("FAIL b2b_latest_target: got %h want 200", imemAddr); end
    imemData = 32'hD000_0200; freeze = 1'b1;
    step();
    tests++; if (imemReq !== 1'b0) begin fails++; $display("FAIL b2b_hold_req: got %b want 0", imemReq); end
    branchTaken = 1'b1; branchAddr = 32'h300;
    step();
    branchTaken = 1'b0;
    tests++; if (valid !== 1'b0 || imemAddr !== 32'h300 || imemReq !== 1'b1) begin fails++; $display("FAIL b2b_hold_branch: got %b/%h/%b want 0/300/1", valid, imemAddr, imemReq); end
    freeze = 1'b0; imemData = 32'hD000_0300;
    step();
    tests++; if (inst !== 32'hD000_0300 || pcOut !== 32'h304 || valid !== 1'b1) begin fails++; $display("FAIL b2b_deliver: got %h/%h/%b want d0000300/304/1", inst, pcOut, valid); end
    imemReady = 1'b0;
  endtask

  // Async reset mid-fetch at 0x40, restart, and PC wrap.
  task automatic test_async_reset_wrap();
    do_reset();
    imemReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      imemData = 32'(4 * i);
      step();
    end
    imemReady = 1'b0;
    tests++; if (imemAddr !== 32'h40 || valid !== 1'b1) begin fails++; $display("FAIL ar_pre: got %h/%b want 40/1", imemAddr, valid); end
    #2 rst = 1'b0;
    #1;
    tests++; if (valid !== 1'b0 || inst !== 32'd0 || pcOut !== 32'd0 || imemReq !== 1'b0) begin fails++; $display("FAIL ar_immediate: got %b/%h/%h/%b want 0/0/0/0", valid, inst, pcOut, imemReq); end
    step();
    rst = 1'b1;
    #1;
    tests++; if (imemAddr !== 32'd0 || imemReq !== 1'b1) begin fails++; $display("FAIL ar_restart: got %h/%b want 0/1", imemAddr, imemReq); end
    branchTaken = 1'b1; branchAddr = 32'hFFFF_FFFC; imemReady = 1'b1; imemData = 32'hBAD0_0000;
    step();
    branchTaken = 1'b0; imemData = 32'hE000_FFFC;
    tests++; if (imemAddr !== 32'hFFFF_FFFC || valid !== 1'b0) begin fails++; $display("FAIL wrap_addr: got %h/%b want fffffffc/0", imemAddr, valid); end
    step();
    tests++; if (pcOut !== 32'd0 || inst !== 32'hE000_FFFC || valid !== 1'b1) begin fails++; $display("FAIL wrap_pcout: got %h/%h/%b want 0/e000fffc/1", pcOut, inst, valid); end
    tests++; if (imemAddr !== 32'd0) begin fails++; $display("FAIL wrap_next_addr: got %h want 0", imemAddr); end
    imemReady = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_freeze();
    test_branch_drain();
    test_back_to_back();
    test_async_reset_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_if_fetch.md
Name: stage_if_fetch

Overview:
- Instruction-fetch stage of the ARM pipeline, directly upstream of the IF/ID register and the decode stage.
- Owns the PC and issues word fetches to a variable-latency instruction memory over a req/ready handshake.
- Delivers {inst, pcOut = fetch address + 4, valid} to IF/ID.
- Honours hazard freeze and EX-stage branch redirects, including redirects that arrive while a fetch is outstanding.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset
PC_STEP, 32'd4, sequential PC increment

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
freeze  input  1  hazard stall from the hazard unit; hold outputs, no new delivery
branchTaken  input  1  one-cycle redirect pulse from EX
branchAddr  input  32  redirect target, valid with branchTaken
imemReq  output  1  fetch request to instruction memory
imemAddr  output  32  fetch address; stable while imemReq=1 and imemReady=0
imemReady  input  1  memory completion; imemData valid this cycle
imemData  input  32  fetched instruction word
inst  output  32  instruction to IF/ID
pcOut  output  32  fetch address + PC_STEP to IF/ID
valid  output  1  inst/pcOut hold a live instruction (0 = bubble)

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=FETCH.
  - inst=0, pcOut=0, valid=0, internal hold/drain registers=0.
  - imemReq=1 from the first cycle after rst deasserts; imemReq=0 while rst=0.
- Reset mid-operation: any outstanding request is abandoned; memory must tolerate the abandoned request.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - Outputs: imemReq=1, imemAddr=pc.
  - Zero-wait memory is legal: imemReady may rise in the same cycle imemReq is first asserted.
  - imemReady=1, freeze=0: inst<=imemData, pcOut<=pc+PC_STEP, valid<=1, pc<=pc+PC_STEP; stay in FETCH.
  - imemReady=1, freeze=1: holdInst<=imemData, holdPc<=pc+PC_STEP, pc<=pc+PC_STEP; go to HOLD. Outputs unchanged.
  - imemReady=0, freeze=0: valid<=0 (bubble). imemReady=0, freeze=1: all outputs hold.
- HOLD:
  - Outputs: imemReq=0; imemReady is ignored.
  - freeze=1: hold.
  - freeze=0: inst<=holdInst, pcOut<=holdPc, valid<=1; go to FETCH.
- DRAIN (redirect while a request is outstanding):
  - Outputs: imemReq=1, imemAddr=drainAddr (the old address). The request is held until imemReady.
  - imemReady=1: data is discarded; go to FETCH; pc is already the target.
  - Outputs: valid<=0 unless freeze=1, in which case outputs hold.
- branchTaken has priority over freeze and over capture, in every state:
  - pc<=branchAddr, valid<=0, holdInst is discarded.
  - In FETCH with imemReady=0: drainAddr<=pc; go to DRAIN.
  - In FETCH with imemReady=1: imemData is discarded; stay in FETCH.
  - In HOLD: go to FETCH.
  - In DRAIN: pc<=branchAddr (the latest target wins); stay in DRAIN unless imemReady=1, in which case go to FETCH.
- PC arithmetic: 32-bit unsigned, wraps silently (32'hFFFFFFFC + 4 = 0).
- No word-alignment check; branchAddr is used as given.
- Exactly one instruction is delivered per completed non-discarded fetch. There is no duplication and no loss under any interleaving of freeze and imemReady.

Test Plan:
1. Zero-wait memory (imemReady tied 1), RESET_PC=0, data = address → valid=1 from cycle 1; pcOut sequence 4, 8, 12…; inst = 0, 4, 8…
2. 3-cycle memory latency → imemAddr is stable for 3 cycles; valid pulses 1 only in the delivery cycle, otherwise 0; pc advances by 4 per fetch.
3. freeze=1 asserted in the capture cycle, held 4 cycles → outputs unchanged during freeze; imemReq=0 in HOLD; the held word is delivered the cycle after freeze falls; no second fetch is issued meanwhile.
4. branchTaken, branchAddr=32'h100, raised while a 3-cycle fetch of 0x8 is outstanding → imemAddr stays 0x8 until ready; that data is dropped (valid=0); the next fetch goes to 0x100 and pcOut=0x104.
5. Second branch to 0x200 during DRAIN, then ready, plus branch during HOLD → the next fetch is from 0x200; held data is never delivered.
6. rst pulled low asynchronously mid-fetch at pc=0x40 → immediately valid=0, inst=0, pcOut=0, imemReq=0; after release, the fetch restarts at RESET_PC. Wrap check: pc=32'hFFFFFFFC gives pcOut=0.
